// File: rtl/chi5_pcrd_grant_sched.sv
// CHI5 P-Credit grant scheduler: tracks RetryAcks per requester and issues PCrdGrants round-robin from a credit pool.
// Optional per-source age timeout is enabled with the CHI5PC_PCRD_TIMEOUT_EN macro.
module chi5_pcrd_grant_sched #(
   parameter int unsigned NUM_SRC    = 8,
   parameter int unsigned SRC_W      = 3,
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned MAX_CRD    = 4,
   parameter int unsigned PCRDTYPE_W = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                      SCLK,
   input  logic                      SRESET,
   input  logic                      retry_valid,
   input  logic [SRC_W-1:0]          retry_src,
   input  logic [PCRDTYPE_W-1:0]     retry_pcrdtype,
   input  logic                      crd_release,
   input  logic                      crd_use_valid,
   input  logic [SRC_W-1:0]          crd_use_src,
   output logic                      grant_valid,
   input  logic                      grant_ready,
   output logic [SRC_W-1:0]          grant_src,
   output logic [PCRDTYPE_W-1:0]     grant_pcrdtype,
   output logic [$clog2(MAX_CRD):0]  free_credits,
   output logic                      pending_any,
   output logic                      err
);

   localparam int unsigned CRD_W = $clog2(MAX_CRD) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  stateQ, stateD;
   logic [CNT_W-1:0]        pendingQ [NUM_SRC];
   logic [CNT_W-1:0]        pendingD [NUM_SRC];
   logic [CNT_W-1:0]        outstQ   [NUM_SRC];
   logic [CNT_W-1:0]        outstD   [NUM_SRC];
   logic [PCRDTYPE_W-1:0]   typeQ    [NUM_SRC];
   logic [PCRDTYPE_W-1:0]   typeD    [NUM_SRC];
   logic [CRD_W-1:0]        poolQ, poolD;
   logic [SRC_W-1:0]        rrPtrQ, rrPtrD;
   logic [SRC_W-1:0]        grantSrcQ, grantSrcD;
   logic [PCRDTYPE_W-1:0]   grantTypeQ, grantTypeD;
   logic                    errQ, errD;
   logic [NUM_SRC-1:0]      pendNz;
   logic                    found;
   logic [SRC_W-1:0]        sel;
   logic                    reserve;

`ifdef CHI5PC_PCRD_TIMEOUT_EN
   localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);
   logic [AGE_W-1:0]        ageQ [NUM_SRC];
   logic [AGE_W-1:0]        ageD [NUM_SRC];
`endif

   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         pendNz[i] = (pendingQ[i] != '0);
      end
   end

   assign pending_any = |pendNz;

   // Round-robin search starting at rrPtrQ, wrapping at NUM_SRC
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = 32'(rrPtrQ) + i;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         if (!found && pendNz[idx[SRC_W-1:0]]) begin
            found = 1'b1;
            sel   = idx[SRC_W-1:0];
         end
      end
   end

   always_comb begin
      stateD     = stateQ;
      rrPtrD     = rrPtrQ;
      grantSrcD  = grantSrcQ;
      grantTypeD = grantTypeQ;
      reserve    = 1'b0;
      case (stateQ)
         IDLE: begin
            if (poolQ != '0 && found) begin
               reserve    = 1'b1;
               stateD     = GRANT;
               grantSrcD  = sel;
               grantTypeD = typeQ[sel];
            end
         end
         GRANT: begin
            if (grant_ready) begin
               stateD = IDLE;
               rrPtrD = (grantSrcQ == SRC_W'(NUM_SRC - 1)) ? '0 : grantSrcQ + 1'b1;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      logic retryHit;
      logic resHit;
      logic useHit;
      errD  = errQ;
      poolD = poolQ;
      case ({crd_release, reserve})
         2'b10: begin
            if (poolQ == CRD_W'(MAX_CRD)) errD = 1'b1;
            else                          poolD = poolQ + 1'b1;
         end
         2'b01:   poolD = poolQ - 1'b1;
         default: poolD = poolQ;
      endcase
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         retryHit    = retry_valid && (retry_src == SRC_W'(i));
         resHit      = reserve && (sel == SRC_W'(i));
         useHit      = crd_use_valid && (crd_use_src == SRC_W'(i));
         pendingD[i] = pendingQ[i];
         outstD[i]   = outstQ[i];
         typeD[i]    = typeQ[i];

         if (retryHit && !pendNz[i]) begin
            typeD[i] = retry_pcrdtype;
         end
         if (retryHit && pendNz[i] && (typeQ[i] != retry_pcrdtype)) begin
            errD = 1'b1;
         end

         // A retry and a reservation in the same cycle cancel out, so saturation only matters alone
         case ({retryHit, resHit})
            2'b10: begin
               if (pendingQ[i] == '1) errD = 1'b1;
               else                   pendingD[i] = pendingQ[i] + 1'b1;
            end
            2'b01:   pendingD[i] = pendingQ[i] - 1'b1;
            default: pendingD[i] = pendingQ[i];
         endcase

         case ({resHit, useHit})
            2'b10:   outstD[i] = outstQ[i] + 1'b1;
            2'b01: begin
               if (outstQ[i] == '0) errD = 1'b1;
               else                 outstD[i] = outstQ[i] - 1'b1;
            end
            default: outstD[i] = outstQ[i];
         endcase

`ifdef CHI5PC_PCRD_TIMEOUT_EN
         ageD[i] = ageQ[i];
         if ((retryHit && !pendNz[i]) || resHit) begin
            ageD[i] = '0;
         end else if (pendNz[i] && (ageQ[i] != AGE_W'(TIMEOUT))) begin
            ageD[i] = ageQ[i] + 1'b1;
            if (ageQ[i] == AGE_W'(TIMEOUT - 1)) errD = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge SCLK or posedge SRESET) begin
      if (SRESET) begin
         stateQ     <= IDLE;
         poolQ      <= CRD_W'(MAX_CRD);
         rrPtrQ     <= '0;
         grantSrcQ  <= '0;
         grantTypeQ <= '0;
         errQ       <= 1'b0;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pendingQ[i] <= '0;
            outstQ[i]   <= '0;
            typeQ[i]    <= '0;
`ifdef CHI5PC_PCRD_TIMEOUT_EN
            ageQ[i]     <= '0;
`endif
         end
      end else begin
         stateQ     <= stateD;
         poolQ      <= poolD;
         rrPtrQ     <= rrPtrD;
         grantSrcQ  <= grantSrcD;
         grantTypeQ <= grantTypeD;
         errQ       <= errD;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pendingQ[i] <= pendingD[i];
            outstQ[i]   <= outstD[i];
            typeQ[i]    <= typeD[i];
`ifdef CHI5PC_PCRD_TIMEOUT_EN
            ageQ[i]     <= ageD[i];
`endif
         end
      end
   end

   assign grant_valid    = (stateQ == GRANT);
   assign grant_src      = grantSrcQ;
   assign grant_pcrdtype = grantTypeQ;
   assign free_credits   = poolQ;
   assign err            = errQ;

endmodule
